seq_arith_unit: RTL

Parametrised, multi-cycle arithmetic unit. It performs add, subtract, multiply and divide on WIDTH-bit unsigned operands. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) iterate one bit per cycle behind a start/busy/done handshake. It is the clocked successor of the 4-bit combinational arithmetic unit and reuses the same operation encoding, so it drops in wherever a wider or area-lean datapath is needed.

---
 rtl/seq_arith_pkg.sv | 18 +
 rtl/seq_arith_div_step.sv | 38 +++
 rtl/seq_arith_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// seq_arith_pkg: shared definitions for the sequential arithmetic unit.
//   - OP_ADD/OP_SUB/OP_MUL/OP_DIV: operation encoding, identical to the
//     older 4-bit combinational arithmetic unit.
//   - state_e: control FSM states (IDLE, RUN, FIN).
package seq_arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_arith_div_step.sv
// seq_arith_div_step: one combinational restoring-divide step.
// Ports:
//   rem          in  WIDTH  current partial remainder (always < divisor)
//   dividend_bit in  1      next dividend bit, shifted in at the LSB
//   divisor      in  WIDTH  divisor (non-zero)
//   rem_next     out WIDTH  remainder after the trial subtraction/restore
//   quo_bit      out 1      quotient bit (inverted sign of the trial difference)
module seq_arith_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           neg_s;

    // Shift, trial-subtract and restore.
    always_comb begin
        shifted_s = {rem, dividend_bit};
        trial_s   = shifted_s - {1'b0, divisor};
        // When the shifted remainder reaches 2^WIDTH it always exceeds the
        // divisor; otherwise both fit in WIDTH bits and bit WIDTH of the
        // wrapped difference is the true sign.
        neg_s     = ~shifted_s[WIDTH] & trial_s[WIDTH];
        quo_bit   = ~neg_s;
        if (neg_s) begin
            rem_next = shifted_s[WIDTH-1:0];
        end else begin
            rem_next = trial_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/mul/div on WIDTH-bit operands.
// Add/sub finish in one datapath cycle; mul (shift-add) and div (restoring)
// iterate one bit per cycle behind a start/busy/done handshake.
// Ports:
//   clk     in  1        rising-edge clock
//   rst_n   in  1        synchronous active-low reset
//   start   in  1        request, accepted when idle (not in the done cycle)
//   op      in  2        00 add, 01 sub, 10 mul, 11 div
//   a, b    in  WIDTH    operands (dividend / divisor for div)
//   busy    out 1        operation in flight
//   done    out 1        one-cycle completion pulse
//   result  out 2*WIDTH  result; add/sub carry/borrow in bit WIDTH,
//                        mul full product, div {remainder, quotient}
//   dz      out 1        divide by zero
//   op_err  out 1        unsupported op (div when the divider is not built)
// Build option: define SEQ_ARITH_DIV_EN to include the divider datapath.
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dz,
    output logic               op_err
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_r;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] prod_r;

    logic               accept_s;
    logic               needs_run_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [2*WIDTH-1:0] fin_result_s;
    logic               fin_dz_s;
    logic               fin_err_s;

`ifdef SEQ_ARITH_DIV_EN
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_next_s;
    logic               quo_bit_s;

    // quo_r starts as the dividend; its MSB feeds the step while the
    // quotient bits fill in from the LSB.
    seq_arith_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (rem_r),
        .dividend_bit (quo_r[WIDTH-1]),
        .divisor      (b_r),
        .rem_next     (rem_next_s),
        .quo_bit      (quo_bit_s)
    );

    assign needs_run_s = ((op == OP_MUL) || (op == OP_DIV)) && (b != {WIDTH{1'b0}});
`else
    assign needs_run_s = (op == OP_MUL) && (b != {WIDTH{1'b0}});
`endif

    // The done cycle is already IDLE but must not accept a new request.
    assign accept_s = (state_r == ST_IDLE) && start && !done;

    // Shift-add multiply step and single-cycle add/sub.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        prod_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        add_s       = {1'b0, a_r} + {1'b0, b_r};
        sub_s       = {1'b0, a_r} - {1'b0, b_r};
    end

    // Select the value loaded into result and flags in FIN.
    always_comb begin
        fin_result_s = {(2*WIDTH){1'b0}};
        fin_dz_s     = 1'b0;
        fin_err_s    = 1'b0;
        case (op_r)
            OP_ADD: fin_result_s = {{(WIDTH-1){1'b0}}, add_s};
            OP_SUB: fin_result_s = {{(WIDTH-1){1'b0}}, sub_s};
            OP_MUL: fin_result_s = prod_r;
            OP_DIV: begin
`ifdef SEQ_ARITH_DIV_EN
                if (b_r == {WIDTH{1'b0}}) begin
                    fin_result_s = {a_r, {WIDTH{1'b1}}};
                    fin_dz_s     = 1'b1;
                end else begin
                    fin_result_s = {rem_r, quo_r};
                end
`else
                fin_err_s = 1'b1;
`endif
            end
            default: fin_result_s = {(2*WIDTH){1'b0}};
        endcase
    end

    // Control FSM, iteration counter, datapath registers and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            op_r    <= 2'b00;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
`ifdef SEQ_ARITH_DIV_EN
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= {(2*WIDTH){1'b0}};
            dz      <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= op;
                        a_r    <= a;
                        b_r    <= b;
                        prod_r <= {{WIDTH{1'b0}}, b};
`ifdef SEQ_ARITH_DIV_EN
                        rem_r  <= {WIDTH{1'b0}};
                        quo_r  <= a;
`endif
                        busy   <= 1'b1;
                        if (needs_run_s) begin
                            state_r <= ST_RUN;
                            cnt_r   <= CW'(WIDTH - 1);
                        end else begin
                            state_r <= ST_FIN;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_r == OP_MUL) begin
                        prod_r <= prod_next_s;
                    end
`ifdef SEQ_ARITH_DIV_EN
                    else begin
                        rem_r <= rem_next_s;
                        quo_r <= {quo_r[WIDTH-2:0], quo_bit_s};
                    end
`endif
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIN;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FIN: begin
                    result  <= fin_result_s;
                    dz      <= fin_dz_s;
                    op_err  <= fin_err_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
